// File: rtl/arb_pkg.sv
// arb_pkg: shared types and default parameter values for activity_arbiter.
//   arb_state_t    : arbiter FSM state (IDLE / GRANT / GAP), 2-bit encoding
//   ARB_N_REQ      : default number of requesters
//   ARB_MAX_HOLD   : default maximum tenure length in cycles
//   ARB_GAP_CYCLES : default idle cycles inserted after each tenure
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GRANT = 2'b01,
      GAP   = 2'b10
   } arb_state_t;

   localparam int unsigned ARB_N_REQ      = 4;
   localparam int unsigned ARB_MAX_HOLD   = 16;
   localparam int unsigned ARB_GAP_CYCLES = 1;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector.
// Finds the first set bit of req scanning cyclically upward from ptr.
//   req   in  N_REQ : request vector
//   ptr   in  IDX_W : index where the scan starts (highest priority)
//   valid out 1     : at least one request is set
//   sel   out IDX_W : index of the winning requester (0 when !valid)
module rr_pick
   import arb_pkg::*;
#(
   parameter int unsigned N_REQ = ARB_N_REQ,
   parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             valid,
   output logic [IDX_W-1:0] sel
);

   // Two copies of req side by side; clearing the bits below ptr turns the
   // cyclic search into a plain lowest-set-bit search over 2*N_REQ bits.
   logic [2*N_REQ-1:0] dbl_req;

   always_comb begin
      dbl_req = {req, req};
      for (int unsigned i = 0; i < 2 * N_REQ; i++) begin
         if (i < 32'(ptr)) begin
            dbl_req[i] = 1'b0;
         end
      end

      valid = 1'b0;
      sel   = '0;
      for (int unsigned i = 0; i < 2 * N_REQ; i++) begin
         if (!valid && dbl_req[i]) begin
            valid = 1'b1;
            sel   = IDX_W'(i % N_REQ);
         end
      end
   end

endmodule

// File: rtl/activity_arbiter.sv
// activity_arbiter: round-robin arbiter for one shared ACTIVE-type resource.
// Grants one requester at a time, bounds each tenure to MAX_HOLD cycles,
// inserts GAP_CYCLES idle cycles after every tenure and pulses toggle at each
// tenure start and end so a downstream IDLE/ACTIVE toggle FSM follows grant.
//   clk      in  1     : clock, rising edge
//   rst_n    in  1     : synchronous active-low reset
//   req      in  N_REQ : level requests, held for the whole desired tenure
//   grant    out N_REQ : one-hot grant, zero outside GRANT
//   grant_id out ID_W  : index of current / last granted requester
//   active   out 1     : high while in GRANT
//   toggle   out 1     : pulse on first GRANT cycle and first GAP cycle
//   timeout  out 1     : pulse on first GAP cycle of a MAX_HOLD-ended tenure
// All outputs are registered.
module activity_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned N_REQ      = ARB_N_REQ,
   parameter int unsigned MAX_HOLD   = ARB_MAX_HOLD,
   parameter int unsigned GAP_CYCLES = ARB_GAP_CYCLES,
   localparam int unsigned ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_id,
   output logic             active,
   output logic             toggle,
   output logic             timeout
);

   localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
   localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);

   arb_state_t         state, state_n;
   logic [ID_W-1:0]    ptr, ptr_n;
   logic [HOLD_W-1:0]  hold_cnt, hold_cnt_n;
   logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
   logic [N_REQ-1:0]   grant_n;
   logic [ID_W-1:0]    grant_id_n;
   logic               active_n;
   logic               toggle_n;
   logic               timeout_n;

   logic               pick_valid;
   logic [ID_W-1:0]    pick_sel;
   logic               owner_req;
   logic               hold_full;
   logic [ID_W-1:0]    ptr_after;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (ID_W)
   ) u_pick (
      .req   (req),
      .ptr   (ptr),
      .valid (pick_valid),
      .sel   (pick_sel)
   );

   assign owner_req = req[grant_id];
   assign hold_full = (hold_cnt == HOLD_W'(MAX_HOLD));
   // Rotation restarts just past the last winner; wraps N_REQ-1 -> 0.
   assign ptr_after = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         hold_cnt <= '0;
         gap_cnt  <= '0;
         grant    <= '0;
         grant_id <= '0;
         active   <= 1'b0;
         toggle   <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         state    <= state_n;
         ptr      <= ptr_n;
         hold_cnt <= hold_cnt_n;
         gap_cnt  <= gap_cnt_n;
         grant    <= grant_n;
         grant_id <= grant_id_n;
         active   <= active_n;
         toggle   <= toggle_n;
         timeout  <= timeout_n;
      end
   end

   always_comb begin
      state_n    = state;
      ptr_n      = ptr;
      hold_cnt_n = hold_cnt;
      gap_cnt_n  = gap_cnt;
      grant_n    = grant;
      grant_id_n = grant_id;
      active_n   = active;
      toggle_n   = 1'b0;
      timeout_n  = 1'b0;

      unique case (state)
         IDLE: begin
            if (pick_valid) begin
               state_n           = GRANT;
               grant_n           = '0;
               grant_n[pick_sel] = 1'b1;
               grant_id_n        = pick_sel;
               active_n          = 1'b1;
               toggle_n          = 1'b1;
               hold_cnt_n        = HOLD_W'(1);
            end
         end

         GRANT: begin
            // Release and timeout share one exit; timeout only flags it.
            if (!owner_req || hold_full) begin
               state_n    = GAP;
               grant_n    = '0;
               active_n   = 1'b0;
               toggle_n   = 1'b1;
               timeout_n  = owner_req;
               ptr_n      = ptr_after;
               hold_cnt_n = '0;
               gap_cnt_n  = GAP_W'(1);
            end else begin
               hold_cnt_n = hold_cnt + HOLD_W'(1);
            end
         end

         GAP: begin
            if (gap_cnt == GAP_W'(GAP_CYCLES)) begin
               state_n   = IDLE;
               gap_cnt_n = '0;
            end else begin
               gap_cnt_n = gap_cnt + GAP_W'(1);
            end
         end

         default: begin
            state_n    = IDLE;
            grant_n    = '0;
            active_n   = 1'b0;
            hold_cnt_n = '0;
            gap_cnt_n  = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_activity_arbiter.sv
// tb_activity_arbiter: scoreboard bench for activity_arbiter (N_REQ=4,
// MAX_HOLD=16, GAP_CYCLES=1). A tenure-level reference model predicts each
// tenure start/end with its cycle stamp; a monitor checks every toggle pulse
// against the queued prediction, plus per-cycle grant/active/timeout values.
module tb_activity_arbiter;

   localparam int NR = 4;
   localparam int MH = 16;
   localparam int GP = 1;

   typedef struct {
      int cyc;
      bit start;
      int id;
      bit to;
      int len;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NR-1:0] req;
   logic [NR-1:0] grant;
   logic [1:0]    grant_id;
   logic          active;
   logic          toggle;
   logic          timeout;

   int  errors = 0;
   int  checks = 0;

   ev_t expq[$];
   int  cyc = 0;
   int  m_owner = -1;
   int  m_len = 0;
   int  m_quiet = 0;
   int  m_next = 0;
   bit  chk_rst = 1'b0;
   int  act_cnt = 0;

   logic [NR-1:0] want;
   int  wlen[NR];
   int  served[NR];
   bit  rand_en = 1'b0;

   activity_arbiter #(
      .N_REQ      (NR),
      .MAX_HOLD   (MH),
      .GAP_CYCLES (GP)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .grant    (grant),
      .grant_id (grant_id),
      .active   (active),
      .toggle   (toggle),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: tenures are tracked as owner + elapsed length; after a
   // tenure the arbiter is unavailable for GP gap cycles, then arbitration
   // takes place on the following edge.
   always @(posedge clk) begin
      ev_t e;
      cyc++;
      if (!rst_n) begin
         m_owner = -1;
         m_len   = 0;
         m_quiet = 0;
         m_next  = 0;
         chk_rst = 1'b1;
      end else begin
         chk_rst = 1'b0;
         if (m_owner >= 0) begin
            if (!req[m_owner] || m_len == MH) begin
               e = '{cyc: cyc, start: 1'b0, id: m_owner, to: req[m_owner], len: m_len};
               expq.push_back(e);
               m_next  = (m_owner + 1) % NR;
               m_owner = -1;
               m_quiet = GP;
            end else begin
               m_len++;
            end
         end else if (m_quiet > 0) begin
            m_quiet--;
         end else begin
            for (int k = 0; k < NR; k++) begin
               if (m_owner < 0 && req[(m_next + k) % NR]) begin
                  m_owner = (m_next + k) % NR;
               end
            end
            if (m_owner >= 0) begin
               m_len = 1;
               e = '{cyc: cyc, start: 1'b1, id: m_owner, to: 1'b0, len: 0};
               expq.push_back(e);
            end
         end
      end
   end

   // Monitor
   always @(negedge clk) begin
      ev_t e;
      bit  has_exp;
      if (chk_rst) begin
         chk("rst_grant", grant, 0);
         chk("rst_grant_id", grant_id, 0);
         chk("rst_active", active, 0);
         chk("rst_toggle", toggle, 0);
         chk("rst_timeout", timeout, 0);
         act_cnt = 0;
      end else if (cyc > 0) begin
         chk("cyc_grant", grant, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
         chk("cyc_active", active, (m_owner >= 0) ? 1 : 0);
         if (active) begin
            act_cnt = toggle ? 1 : act_cnt + 1;
         end
         has_exp = (expq.size() > 0) && (expq[0].cyc == cyc);
         chk("toggle_event", toggle, has_exp);
         if (has_exp) begin
            e = expq.pop_front();
            chk("ev_active", active, e.start);
            chk("ev_grant", grant, e.start ? (32'd1 << e.id) : 32'd0);
            chk("ev_grant_id", grant_id, e.id);
            chk("ev_timeout", timeout, e.start ? 0 : e.to);
            if (!e.start) chk("ev_tenure_len", act_cnt, e.len);
         end else begin
            chk("no_timeout", timeout, 0);
         end
      end
   end

   task automatic step();
      bit dropped;
      @(posedge clk);
      #1;
      rst_n = rand_en ? ($urandom_range(299) != 0) : 1'b1;
      for (int i = 0; i < NR; i++) begin
         dropped = 1'b0;
         if (m_owner == i) begin
            served[i]++;
            if (served[i] >= wlen[i]) begin
               want[i] = 1'b0;
               dropped = 1'b1;
            end
         end
         if (rand_en && !dropped) begin
            if (!want[i] && $urandom_range(3) == 0) begin
               want[i]   = 1'b1;
               wlen[i]   = $urandom_range(MH + 3, 1);
               served[i] = 0;
            end else if (want[i] && m_owner != i && served[i] == 0 && $urandom_range(15) == 0) begin
               want[i] = 1'b0;
            end
         end
      end
      req = want;
   endtask

   task automatic ask(input int i, input int len);
      want[i]   = 1'b1;
      wlen[i]   = len;
      served[i] = 0;
      req       = want;
   endtask

   task automatic wait_quiet(input int maxc);
      int n = 0;
      while ((want != '0 || m_owner >= 0 || m_quiet > 0) && n < maxc) begin
         step();
         n++;
      end
      chk("quiet_bound_expired", (n >= maxc), 0);
      step();
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      req   = '0;
      want  = '0;
      for (int i = 0; i < NR; i++) begin
         wlen[i]   = 0;
         served[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      // Single requester, 5-cycle tenure; leaves rotation pointer at 3
      ask(2, 5);
      wait_quiet(50);
      // Pointer at 3: requester 3 wins over 0
      ask(0, 2);
      ask(3, 2);
      wait_quiet(50);

      // Round robin: all four requesting, 2-cycle tenures, twice over
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < NR; i++) ask(i, 2);
         wait_quiet(80);
      end

      // Timeout: requester 0 wants 40 cycles -> 16 + 16 + 8
      ask(0, 40);
      wait_quiet(120);

      // Wrap and skip: get pointer to 3 via requester 2, then 0011
      ask(2, 1);
      wait_quiet(20);
      ask(0, 2);
      ask(1, 2);
      wait_quiet(50);

      // Reset in the 3rd GRANT cycle, requests kept high
      ask(1, 10);
      ask(2, 10);
      n = 0;
      while (!(m_owner >= 0 && m_len == 3) && n < 50) begin
         step();
         n++;
      end
      chk("reset_setup_bound_expired", (n >= 50), 0);
      rst_n = 1'b0;
      step();
      for (int i = 0; i < NR; i++) served[i] = 0;
      wait_quiet(100);

      // Randomized traffic with occasional resets
      rand_en = 1'b1;
      repeat (4000) step();
      rand_en = 1'b0;
      wait_quiet(300);
      repeat (3) step();

      chk("pending_expectations", expq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
